// File: rtl/arith_pkg.sv
// arith_pkg: shared types and constants for the arithmetic drills
// (serial subtractor FSM states and the default operand width).
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int ARITH_W = 6;

endpackage

// File: rtl/full_sub.sv
// full_sub: combinational 1-bit full subtractor, d = a - b - bin with
// borrow out; shared by the serial and ripple subtractor datapaths.
module full_sub (
  output logic o_w_d,
  output logic o_w_bout,
  input  logic i_w_a,
  input  logic i_w_b,
  input  logic i_w_bin
);

  assign o_w_d    = i_w_a ^ i_w_b ^ i_w_bin;
  assign o_w_bout = (~i_w_a & i_w_b) | (~(i_w_a ^ i_w_b) & i_w_bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, one bit per clock LSB first,
// with a start/done handshake around a single full-subtractor cell.
module serial_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input  logic             i_w_clk,
  input  logic             i_w_rst_n,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  output logic             o_w_ready,
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic [WIDTH:0]   o_w_d
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH:0]   res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             diff_bit;
  logic             diff_bout;

  full_sub u_full_sub (
    .o_w_d    (diff_bit),
    .o_w_bout (diff_bout),
    .i_w_a    (sa_q[0]),
    .i_w_b    (sb_q[0]),
    .i_w_bin  (bor_q)
  );

  // Result bits enter from the MSB side so bit 0 of the operands lands in bit 0 after WIDTH steps.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    case (state_q)
      IDLE: begin
        if (i_w_start) begin
          state_d = RUN;
          sa_d    = i_w_a;
          sb_d    = i_w_b;
          res_d   = '0;
          cnt_d   = '0;
          bor_d   = 1'b0;
        end
      end
      RUN: begin
        sa_d              = sa_q >> 1;
        sb_d              = sb_q >> 1;
        res_d[WIDTH-1:0]  = {diff_bit, res_q[WIDTH-1:1]};
        bor_d             = diff_bout;
        cnt_d             = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          res_d[WIDTH] = diff_bout;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
    end
  end

  assign o_w_ready = (state_q == IDLE);
  assign o_w_busy  = (state_q == RUN) || (state_q == DONE);
  assign o_w_done  = (state_q == DONE);
  assign o_w_d     = res_q;

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial unsigned subtractor. It computes `i_w_a - i_w_b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the multi-cycle, area-minimal counterpart to the combinational ripple adders in the arithmetic drills. It also serves as the reference sequential datapath with a start/done handshake for later ALU tasks.

## Interface
- `WIDTH`, default 6: operand width in bits; result width is `WIDTH+1`.
- `i_w_clk` input 1: clock, rising-edge active.
- `i_w_rst_n` input 1: reset, asynchronous, active-low.
- `i_w_start` input 1: start request; sampled only in IDLE.
- `i_w_a` input `WIDTH`: minuend; captured on the accepted start edge.
- `i_w_b` input `WIDTH`: subtrahend; captured on the accepted start edge.
- `o_w_ready` output 1: high in IDLE only.
- `o_w_busy` output 1: high in RUN and DONE.
- `o_w_done` output 1: one-cycle pulse, high in DONE.
- `o_w_d` output `WIDTH+1`: result.
  - `o_w_d[WIDTH]` is the final borrow (1 iff a < b unsigned).
  - `o_w_d[WIDTH-1:0]` is (a - b) mod 2^WIDTH.

## Operation
- States and transitions:
  - IDLE -> RUN when `i_w_start`=1.
  - RUN -> DONE after `WIDTH` bit steps.
  - DONE -> IDLE unconditionally.
- Accepted start edge:
  - load `i_w_a` and `i_w_b` into shift registers `sa` and `sb`;
  - clear the borrow flip-flop and the bit counter `cnt` (width `$clog2(WIDTH+1)`);
  - clear the result shift register.
- Each RUN edge:
  - `d = sa[0] ^ sb[0] ^ bor`
  - `bor_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor)`
  - shift `sa` and `sb` right by 1;
  - shift `d` into the result from the MSB side (bit `WIDTH-1`);
  - `cnt++`.
- When `cnt` reaches `WIDTH-1` on a RUN edge, that edge processes the last bit, writes `bor_next` into `o_w_d[WIDTH]`, and moves to DONE.
- `o_w_d` holds its value from DONE until the next accepted start. The start edge clears it to 0. Partial shifts are visible during RUN; consumers use `o_w_d` only on or after `o_w_done`.
- `i_w_start` is ignored in RUN and DONE. A start held high through DONE is accepted on the first IDLE cycle.
- Operand inputs may change freely after the start edge.
- Async reset at any time, including mid-RUN:
  - state goes to IDLE;
  - `o_w_ready`=1, `o_w_busy`=0, `o_w_done`=0;
  - `o_w_d`=0, `cnt`=0, borrow=0;
  - any in-flight operation is discarded.

## Timing
- Edge 0: start accepted. Edges 1..`WIDTH`: bit steps. Edge `WIDTH`: transition to DONE.
- `o_w_done`=1 for exactly the one cycle following edge `WIDTH`. Total latency from start edge to done is `WIDTH`+1 cycles (7 for the default).
- Back-to-back throughput is one result per `WIDTH`+2 cycles: the DONE cycle plus one IDLE cycle before the next start is accepted.
- All outputs are registered or decoded directly from the state register; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `arith_pkg`:
  - state enum `sub_state_t` {IDLE, RUN, DONE}, 2-bit encoding;
  - constant `ARITH_W = 6`, used as the default width.
- One sub-module, `full_sub`: a combinational 1-bit full subtractor.
  - Ports: `o_w_d`, `o_w_bout`, `i_w_a`, `i_w_b`, `i_w_bin`.
  - Instantiated once on the serial datapath.
  - Reusable for the combinational ripple subtractor drill.

## Test plan
- Reset released, no start -> `o_w_ready`=1, `o_w_busy`=0, `o_w_d`=7'h00 indefinitely.
- a=45, b=18 -> `o_w_done` 7 cycles after start; `o_w_d`=7'b0011011 (27, borrow 0).
- a=18, b=45 -> `o_w_d`=7'b1100101 (borrow 1, 37 = -27 mod 64). Also a=0, b=1 -> 7'h7F.
- a=63, b=63 -> `o_w_d`=7'h00. Then an immediate second start with a=63, b=0 in the first IDLE cycle -> 7'h3F.
- Start pulsed again mid-RUN with different operands -> ignored; the original result is produced and `o_w_done` pulses exactly once.
- `i_w_rst_n` asserted at RUN bit 3 -> outputs return to reset values immediately. A new start after release (a=10, b=3) yields 7'h07.
